// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Instruction/data port arbiter onto one single-ported memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int SIZE_LOG2    = 13,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    // instruction port
    input  logic                 i_req,
    input  logic [SIZE_LOG2-1:0] i_addr,
    output logic                 i_gnt,
    output logic                 i_rvalid,
    output logic [31:0]          i_rdata,
    // data port
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [1:0]           d_size,
    input  logic                 d_signed,
    input  logic [SIZE_LOG2-1:0] d_addr,
    input  logic [31:0]          d_wdata,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [31:0]          d_rdata,
    output logic                 d_err,
    // memory side
    output logic                 m_we,
    output logic [1:0]           m_size,
    output logic                 m_signed,
    output logic [SIZE_LOG2-1:0] m_addr,
    output logic [31:0]          m_wdata,
    input  logic [31:0]          m_rd
);

    localparam int            CW      = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] C_LIMIT = CW'(STARVE_LIMIT);
    localparam logic [1:0]    C_WORD  = 2'b10;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        RD_I = 2'd1,
        RD_D = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_starve;
    logic          r_d_err;

    logic w_d_legal;
    logic w_i_win;

    assign w_d_legal = (d_size != 2'b11);
    // Data normally wins; a starved instruction port takes one cycle back.
    assign w_i_win   = i_req && (!d_req || (r_starve == C_LIMIT));

    assign i_gnt = !rst && w_i_win;
    assign d_gnt = !rst && d_req && !w_i_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= NONE;
            r_starve <= '0;
            r_d_err  <= 1'b0;
        end else begin
            if (i_req && !i_gnt)
                r_starve <= (r_starve == C_LIMIT) ? r_starve : r_starve + 1'b1;
            else
                r_starve <= '0;

            if (i_gnt)
                r_state <= RD_I;
            else if (d_gnt && !d_we && w_d_legal)
                r_state <= RD_D;
            else
                r_state <= NONE;

            r_d_err <= d_gnt && !w_d_legal;
        end
    end

    // Read data is passed straight from memory; rst masks a pending response.
    assign i_rvalid = !rst && (r_state == RD_I);
    assign d_rvalid = !rst && (r_state == RD_D);
    assign i_rdata  = i_rvalid ? m_rd : 32'd0;
    assign d_rdata  = d_rvalid ? m_rd : 32'd0;
    assign d_err    = !rst && r_d_err;

    always_comb begin
        m_we     = 1'b0;
        m_size   = C_WORD;
        m_signed = 1'b0;
        m_addr   = '0;
        m_wdata  = 32'd0;
        if (i_gnt) begin
            m_addr = i_addr;
        end else if (d_gnt) begin
            // Illegal size degrades to a harmless word read with no response.
            m_we     = d_we && w_d_legal;
            m_size   = w_d_legal ? d_size : C_WORD;
            m_signed = d_signed;
            m_addr   = d_addr;
            m_wdata  = d_wdata;
        end
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter SIZE_LOG2, default 13, byte-address width of the shared memory.
REQ-002 Parameter STARVE_LIMIT, default 3, consecutive denied instruction-port cycles before instruction priority.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 i_req  in  1  instruction port requests a word read this cycle.
REQ-006 i_addr  in  SIZE_LOG2  instruction byte address.
REQ-007 i_gnt  out  1  instruction request accepted this cycle.
REQ-008 i_rvalid  out  1  instruction read data valid.
REQ-009 i_rdata  out  32  instruction read data.
REQ-010 d_req  in  1  data port requests an access this cycle.
REQ-011 d_we  in  1  data access is a write.
REQ-012 d_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-013 d_signed  in  1  sign-extend byte/halfword reads.
REQ-014 d_addr  in  SIZE_LOG2  data byte address (unaligned allowed).
REQ-015 d_wdata  in  32  write data, LSB-justified.
REQ-016 d_gnt  out  1  data request accepted this cycle.
REQ-017 d_rvalid  out  1  data read data valid.
REQ-018 d_rdata  out  32  data read data.
REQ-019 d_err  out  1  one-cycle pulse: granted access had d_size=11.
REQ-020 m_we, m_size[1:0], m_signed, m_addr[SIZE_LOG2-1:0], m_wdata[31:0]  out  memory command, combinational from the granted port.
REQ-021 m_rd  in  32  memory read data, valid one cycle after the read command.

Function
REQ-022 At most one of i_gnt, d_gnt SHALL be high in any cycle; a grant is combinational on the same-cycle request (no extra cycle).
REQ-023 Default priority: data over instruction when both request.
REQ-024 Starvation counter (width clog2(STARVE_LIMIT+1)) SHALL increment, saturating at STARVE_LIMIT, each cycle i_req=1 and i_gnt=0; clear when i_gnt=1 or i_req=0.
REQ-025 When counter==STARVE_LIMIT and i_req=1, instruction SHALL win over data for that cycle.
REQ-026 Instruction grant drives m_we=0, m_size=10, m_signed=0, m_addr=i_addr, m_wdata=0.
REQ-027 Data grant drives m_we=d_we, m_size=d_size, m_signed=d_signed, m_addr=d_addr, m_wdata=d_wdata.
REQ-028 Data grant with d_size=11 SHALL force m_we=0, m_size=10, produce no d_rvalid, and pulse d_err the following cycle.
REQ-029 No grant: m_we=0, m_size=10, m_signed=0, m_addr=0, m_wdata=0.
REQ-030 Response FSM states: NONE, RD_I, RD_D; next state RD_I after a granted instruction read, RD_D after a granted legal data read, else NONE; evaluated every cycle (back-to-back reads allowed).
REQ-031 In RD_I: i_rvalid=1, i_rdata=m_rd; in RD_D: d_rvalid=1, d_rdata=m_rd; read latency exactly one cycle after grant.
REQ-032 rdata outputs SHALL be 0 whenever the matching rvalid is 0.
REQ-033 Granted data writes SHALL produce no rvalid; a read may be granted the cycle after a write.
REQ-034 A requester dropping req without grant SHALL leave no state besides counter clearing.

Reset
REQ-035 While rst=1: state NONE, counter 0, i_gnt=d_gnt=0, both rvalid 0, both rdata 0, d_err 0, m_we 0, m_* as REQ-029.
REQ-036 Reset asserted the cycle after a read grant SHALL suppress that rvalid; first grant possible the cycle rst is low.

Verification
REQ-037 d_req=1 (read, size 10, addr 0x10), i_req=0 -> d_gnt=1 same cycle; next cycle d_rvalid=1, d_rdata=m_rd.
REQ-038 i_req and d_req held 1 continuously, STARVE_LIMIT=3 -> grant pattern D,D,D,I,D,D,D,I; counter reaches 3 before each I grant.
REQ-039 Alternating granted reads I@0x0 then D@0x4 -> i_rvalid at cycle 1, d_rvalid at cycle 2, never both high.
REQ-040 d_req write size 00 addr 0x3 wdata 0xAB -> m_we=1, m_size=00, m_addr=0x3; no rvalid next cycle.
REQ-041 d_req with d_size=11, d_we=1 -> d_gnt=1, m_we=0, d_err=1 next cycle, d_rvalid=0.
REQ-042 rst=1 in cycle after granted read -> i_rvalid=d_rvalid=0 that cycle and outputs per REQ-035.
